// File: rtl/smg_scan_if.sv
// Signal bundle between the taxi-meter top level and the seven-segment scan sequencer.
// The top level drives the controls and BCD values; the sequencer drives the digit/mode selects.
interface smg_scan_if;
    logic        en;
    logic        auto_en;
    logic        key_mode;
    logic [15:0] fee;
    logic [15:0] distance;
    logic [1:0]  Bit_Sel;
    logic        d_m;
    logic        blank;
    logic        frame_done;
    logic        mode_chg;

    modport master (
        output en, auto_en, key_mode, fee, distance,
        input  Bit_Sel, d_m, blank, frame_done, mode_chg
    );

    modport slave (
        input  en, auto_en, key_mode, fee, distance,
        output Bit_Sel, d_m, blank, frame_done, mode_chg
    );
endinterface

// File: rtl/smg_scan_ctrl.sv
// Digit-scan and fee/distance sequencer for the 4-digit seven-segment display.
// d_m only changes on frame boundaries, so one frame never mixes fee and distance digits.
module smg_scan_ctrl #(
    parameter int SCAN_DIV    = 50000,
    parameter int HOLD_FRAMES = 500,
    parameter int DEB_CYCLES  = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    smg_scan_if.slave  bus
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int FW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
    localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    localparam logic [PW-1:0] PRE_LAST  = PW'(SCAN_DIV - 1);
    localparam logic [FW-1:0] HOLD_LAST = FW'(HOLD_FRAMES - 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);

    localparam logic [0:0] ST_FEE  = 1'b0;
    localparam logic [0:0] ST_DIST = 1'b1;

    logic [PW-1:0] pre_cnt;
    logic [1:0]    bit_sel;
    logic [0:0]    state;
    logic          frame_done_q;
    logic          mode_chg_q;
    logic [FW-1:0] frame_cnt;
    logic          toggle_pending;
    logic          sync1;
    logic          sync2;
    logic [DW-1:0] deb_cnt;
    logic          key_state;
    logic          blank_c;
    logic [15:0]   shown;

    logic tick;
    logic boundary;
    logic key_diff;
    logic key_accept;
    logic press;
    logic do_toggle;

    assign tick       = bus.en && (pre_cnt == PRE_LAST);
    assign boundary   = tick && (bit_sel == 2'd3);
    assign key_diff   = (sync2 != key_state);
    assign key_accept = key_diff && (deb_cnt == DEB_LAST);
    assign press      = key_accept && sync2;
    // A pending press wins over auto expiry; both at once still give one toggle.
    assign do_toggle  = boundary && (toggle_pending || (bus.auto_en && (frame_cnt == HOLD_LAST)));

    // NOTE: every clocked register uses <= so all flops sample pre-edge values, like real hardware.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt      <= '0;
            bit_sel      <= 2'd0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= boundary;
            if (tick) begin
                pre_cnt <= '0;
                bit_sel <= bit_sel + 2'd1;
            end else if (bus.en) begin
                pre_cnt <= pre_cnt + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_FEE;
            mode_chg_q <= 1'b0;
        end else begin
            mode_chg_q <= do_toggle;
            case (state)
                ST_FEE:  if (do_toggle) state <= ST_DIST;
                ST_DIST: if (do_toggle) state <= ST_FEE;
                default: state <= ST_FEE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
        end else if (!bus.auto_en) begin
            frame_cnt <= '0;
        end else if (boundary) begin
            if (toggle_pending || (frame_cnt == HOLD_LAST)) frame_cnt <= '0;
            else                                            frame_cnt <= frame_cnt + FW'(1);
        end
    end

    // A press landing on a boundary sets pending and is served at the following boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        toggle_pending <= 1'b0;
        else if (press)    toggle_pending <= 1'b1;
        else if (boundary) toggle_pending <= 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            deb_cnt   <= '0;
            key_state <= 1'b0;
        end else begin
            sync1 <= bus.key_mode;
            sync2 <= sync1;
            if (!key_diff) begin
                deb_cnt <= '0;
            end else if (key_accept) begin
                key_state <= sync2;
                deb_cnt   <= '0;
            end else begin
                deb_cnt <= deb_cnt + DW'(1);
            end
        end
    end

    // NOTE: blank_c gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        blank_c = 1'b0;
        shown   = (state == ST_DIST) ? bus.distance : bus.fee;
        case (bit_sel)
            2'd0:    blank_c = (shown[15:12] == 4'd0);
            2'd1:    blank_c = (shown[15:8]  == 8'd0);
            2'd2:    blank_c = (shown[15:4]  == 12'd0);
            default: blank_c = 1'b0;
        endcase
    end

    assign bus.Bit_Sel    = bit_sel;
    assign bus.d_m        = state[0];
    assign bus.blank      = blank_c;
    assign bus.frame_done = frame_done_q;
    assign bus.mode_chg   = mode_chg_q;

endmodule
